// File: rtl/fish_ride_tracker.sv
// fish_ride_tracker
// Tracks the frog against one fish lane. It decides whether the frog is riding the
// fish, is in the water, or has drowned. While riding, it issues one-pixel carry-left
// pulses as the fish steps. It pulses drown on entry to the drowned state.
//
// Optional feature macro: FISH_RIDE_GRACE_EN
//   defined   - the frog may sit in WATER for GRACE_CYCLES cycles before drowning.
//   undefined - no grace counter is built; losing the fish on the lane drowns at once.
//
// Ports:
//   frame_clk  in   sole clock
//   Reset      in   asynchronous active-high reset
//   frogX/Y    in   frog left/top edge (10 bit)
//   fishX      in   fish left edge from the lane generator (10 bit)
//   fishY      in   lane Y, constant per lane (10 bit)
//   fishMoved  in   one-cycle pulse when fishX has just stepped
//   carryLeft  out  one-cycle pulse: frog mover decrements frogX by 1
//   drown      out  one-cycle pulse on entry to DROWNED
//   riding     out  high while in RIDING
//   state      out  0 OFF_LANE, 1 RIDING, 2 WATER, 3 DROWNED
module fish_ride_tracker #(
    parameter int unsigned FISH_W       = 48,
    parameter int unsigned FROG_W       = 16,
    parameter int unsigned LEFT_BOUND   = 207,
    parameter int unsigned GRACE_CYCLES = 2000000
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] frogX,
    input  logic [9:0] frogY,
    input  logic [9:0] fishX,
    input  logic [9:0] fishY,
    input  logic       fishMoved,
    output logic       carryLeft,
    output logic       drown,
    output logic       riding,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        OFF_LANE = 2'd0,
        RIDING   = 2'd1,
        WATER    = 2'd2,
        DROWNED  = 2'd3
    } state_t;

    localparam logic [10:0] HALF_FROG  = 11'(FROG_W / 2);
    localparam logic [10:0] FISH_SPAN  = 11'(FISH_W - 1);
    // centre - 1 < LEFT_BOUND rewritten as centre < LEFT_BOUND + 1 to avoid underflow.
    localparam logic [10:0] EDGE_LIMIT = 11'(LEFT_BOUND + 1);

`ifdef FISH_RIDE_GRACE_EN
    localparam state_t      ST_LOST    = WATER;
    localparam logic [21:0] GRACE_LAST = 22'(GRACE_CYCLES - 1);
`else
    localparam state_t      ST_LOST    = DROWNED;
`endif

    state_t      r_state;
    state_t      w_state_d;
    logic        r_carry;
    logic        r_drown;
    logic        r_riding;
    logic        w_carry_d;
    logic        w_drown_d;

    logic        w_on_lane;
    logic [10:0] w_centre;
    logic [10:0] w_fish_right;
    logic        w_overlap;
    logic        w_at_edge;

    // All arithmetic at 11 bits so fishX + FISH_W - 1 cannot wrap.
    assign w_on_lane    = (frogY == fishY);
    assign w_centre     = {1'b0, frogX} + HALF_FROG;
    assign w_fish_right = {1'b0, fishX} + FISH_SPAN;
    assign w_overlap    = w_on_lane && (w_centre >= {1'b0, fishX}) && (w_centre <= w_fish_right);
    assign w_at_edge    = (w_centre < EDGE_LIMIT);

`ifdef FISH_RIDE_GRACE_EN
    logic [21:0] r_grace_cnt;
    logic [21:0] w_grace_d;
`endif

    always_comb begin
        w_state_d = r_state;
        w_carry_d = 1'b0;
`ifdef FISH_RIDE_GRACE_EN
        // Cleared everywhere except while counting in WATER, so every WATER entry starts at 0.
        w_grace_d = '0;
`endif
        unique case (r_state)
            OFF_LANE: begin
                if (w_overlap) begin
                    w_state_d = RIDING;
                end else if (w_on_lane) begin
                    w_state_d = ST_LOST;
                end
            end
            RIDING: begin
                if (!w_on_lane) begin
                    w_state_d = OFF_LANE;
                end else if (fishMoved && w_at_edge) begin
                    // Carried past the left bound; also catches a fish wrap-around.
                    w_state_d = DROWNED;
                end else if (fishMoved) begin
                    w_carry_d = 1'b1;
                end else if (!w_overlap) begin
                    w_state_d = ST_LOST;
                end
            end
`ifdef FISH_RIDE_GRACE_EN
            WATER: begin
                if (!w_on_lane) begin
                    w_state_d = OFF_LANE;
                end else if (w_overlap) begin
                    w_state_d = RIDING;
                end else if (r_grace_cnt == GRACE_LAST) begin
                    w_state_d = DROWNED;
                end else begin
                    w_grace_d = r_grace_cnt + 22'd1;
                end
            end
`else
            WATER: begin
                w_state_d = OFF_LANE;
            end
`endif
            DROWNED: begin
                if (!w_on_lane) begin
                    w_state_d = OFF_LANE;
                end
            end
            default: begin
                w_state_d = OFF_LANE;
            end
        endcase
        w_drown_d = (w_state_d == DROWNED) && (r_state != DROWNED);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= OFF_LANE;
            r_carry  <= 1'b0;
            r_drown  <= 1'b0;
            r_riding <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_carry  <= w_carry_d;
            r_drown  <= w_drown_d;
            r_riding <= (w_state_d == RIDING);
        end
    end

`ifdef FISH_RIDE_GRACE_EN
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_grace_cnt <= '0;
        end else begin
            r_grace_cnt <= w_grace_d;
        end
    end
`endif

    assign carryLeft = r_carry;
    assign drown     = r_drown;
    assign riding    = r_riding;
    assign state     = r_state;

endmodule

// File: tb/tb_fish_ride_tracker.sv
// Directed self-checking bench for fish_ride_tracker (GRACE_CYCLES = 10).
module tb_fish_ride_tracker;

    logic       clk;
    logic       rst;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic [9:0] fish_x;
    logic [9:0] fish_y;
    logic       fish_moved;
    logic       carry_left;
    logic       drown;
    logic       riding;
    logic [1:0] state;

    int checks;
    int errors;

    fish_ride_tracker #(
        .FISH_W      (48),
        .FROG_W      (16),
        .LEFT_BOUND  (207),
        .GRACE_CYCLES(10)
    ) dut (
        .frame_clk(clk),
        .Reset    (rst),
        .frogX    (frog_x),
        .frogY    (frog_y),
        .fishX    (fish_x),
        .fishY    (fish_y),
        .fishMoved(fish_moved),
        .carryLeft(carry_left),
        .drown    (drown),
        .riding   (riding),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with the frog overlapping the fish; release and ride.
    task automatic start_riding(input logic [9:0] fx, input logic [9:0] frx);
        rst        = 1'b1;
        fish_moved = 1'b0;
        fish_y     = 10'd222;
        frog_y     = 10'd222;
        fish_x     = fx;
        frog_x     = frx;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        start_riding(10'd300, 10'd310);
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || riding !== 1'b0 || carry_left !== 1'b0 || drown !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: state=%0d riding=%0b carry=%0b drown=%0b, required 0 0 0 0",
                     state, riding, carry_left, drown);
        end
        step();
        step();
        checks++;
        if (state !== 2'd0 || riding !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: state=%0d riding=%0b, required 0 0", state, riding);
        end
        rst = 1'b0;
        step();
        checks++;
        if (state !== 2'd1 || riding !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: state=%0d riding=%0b, required 1 1", state, riding);
        end
    endtask

    task automatic test_carry();
        start_riding(10'd300, 10'd310);
        for (int i = 0; i < 5; i++) begin
            fish_moved = 1'b1;
            fish_x     = fish_x - 10'd1;
            step();
            fish_moved = 1'b0;
            checks++;
            if (carry_left !== 1'b1 || state !== 2'd1) begin
                errors++;
                $display("FAIL carry_pulse[%0d]: carry=%0b state=%0d, required 1 1",
                         i, carry_left, state);
            end
            frog_x = frog_x - 10'd1;
            step();
            checks++;
            if (carry_left !== 1'b0) begin
                errors++;
                $display("FAIL carry_single[%0d]: carry=%0b, required 0", i, carry_left);
            end
        end
        checks++;
        if (frog_x !== 10'd305 || riding !== 1'b1) begin
            errors++;
            $display("FAIL carry_final: frogX=%0d riding=%0b, required 305 1", frog_x, riding);
        end
    endtask

    task automatic test_leave_priority();
        start_riding(10'd300, 10'd310);
        fish_moved = 1'b1;
        frog_y     = 10'd400;
        step();
        fish_moved = 1'b0;
        checks++;
        if (state !== 2'd0 || carry_left !== 1'b0 || riding !== 1'b0) begin
            errors++;
            $display("FAIL leave_priority: state=%0d carry=%0b riding=%0b, required 0 0 0",
                     state, carry_left, riding);
        end
        // fishMoved while off the lane must not carry.
        fish_moved = 1'b1;
        step();
        fish_moved = 1'b0;
        checks++;
        if (carry_left !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL off_lane_moved: carry=%0b state=%0d, required 0 0", carry_left, state);
        end
    endtask

    task automatic test_edge_drown();
        start_riding(10'd200, 10'd199);  // centre 207
        fish_moved = 1'b1;
        fish_x     = 10'd199;
        step();
        fish_moved = 1'b0;
        checks++;
        if (drown !== 1'b1 || state !== 2'd3 || carry_left !== 1'b0 || riding !== 1'b0) begin
            errors++;
            $display("FAIL edge_drown: drown=%0b state=%0d carry=%0b riding=%0b, required 1 3 0 0",
                     drown, state, carry_left, riding);
        end
        step();
        checks++;
        if (drown !== 1'b0 || state !== 2'd3) begin
            errors++;
            $display("FAIL drown_once: drown=%0b state=%0d, required 0 3", drown, state);
        end
        frog_y = 10'd400;
        step();
        checks++;
        if (state !== 2'd0 || drown !== 1'b0) begin
            errors++;
            $display("FAIL drowned_exit: state=%0d drown=%0b, required 0 0", state, drown);
        end
    endtask

    // Centre 208: edge rule not met, carry allowed.
    task automatic test_edge_boundary();
        start_riding(10'd200, 10'd200);
        fish_moved = 1'b1;
        fish_x     = 10'd199;
        step();
        fish_moved = 1'b0;
        checks++;
        if (carry_left !== 1'b1 || state !== 2'd1 || drown !== 1'b0) begin
            errors++;
            $display("FAIL edge_boundary: carry=%0b state=%0d drown=%0b, required 1 1 0",
                     carry_left, state, drown);
        end
    endtask

`ifdef FISH_RIDE_GRACE_EN
    task automatic test_grace_drown();
        start_riding(10'd300, 10'd310);
        frog_y = 10'd400;
        step();
        frog_x = 10'd100;
        frog_y = 10'd222;
        step();
        checks++;
        if (state !== 2'd2 || drown !== 1'b0) begin
            errors++;
            $display("FAIL water_entry: state=%0d drown=%0b, required 2 0", state, drown);
        end
        for (int i = 1; i < 10; i++) begin
            step();
            checks++;
            if (state !== 2'd2 || drown !== 1'b0) begin
                errors++;
                $display("FAIL water_wait[%0d]: state=%0d drown=%0b, required 2 0",
                         i, state, drown);
            end
        end
        step();
        checks++;
        if (state !== 2'd3 || drown !== 1'b1) begin
            errors++;
            $display("FAIL grace_drown: state=%0d drown=%0b, required 3 1", state, drown);
        end
    endtask

    task automatic test_grace_rescue();
        start_riding(10'd300, 10'd310);
        frog_y = 10'd400;
        step();
        frog_x = 10'd100;
        frog_y = 10'd222;
        step();
        for (int i = 1; i < 5; i++) step();
        frog_x = 10'd310;
        step();
        checks++;
        if (state !== 2'd1 || riding !== 1'b1) begin
            errors++;
            $display("FAIL grace_rescue: state=%0d riding=%0b, required 1 1", state, riding);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (drown !== 1'b0 || state !== 2'd1) begin
                errors++;
                $display("FAIL rescue_hold[%0d]: drown=%0b state=%0d, required 0 1",
                         i, drown, state);
            end
        end
    endtask
`else
    task automatic test_no_grace();
        start_riding(10'd300, 10'd310);
        frog_y = 10'd400;
        step();
        frog_x = 10'd100;
        frog_y = 10'd222;
        step();
        checks++;
        if (state !== 2'd3 || drown !== 1'b1) begin
            errors++;
            $display("FAIL land_drown: state=%0d drown=%0b, required 3 1", state, drown);
        end
        // Hopping sideways off the fish also drowns at once.
        start_riding(10'd300, 10'd310);
        frog_x = 10'd100;
        step();
        checks++;
        if (state !== 2'd3 || drown !== 1'b1 || carry_left !== 1'b0) begin
            errors++;
            $display("FAIL hop_off_drown: state=%0d drown=%0b carry=%0b, required 3 1 0",
                     state, drown, carry_left);
        end
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        frog_x     = '0;
        frog_y     = '0;
        fish_x     = '0;
        fish_y     = '0;
        fish_moved = 1'b0;
        test_reset();
        test_carry();
        test_leave_priority();
        test_edge_drown();
        test_edge_boundary();
`ifdef FISH_RIDE_GRACE_EN
        test_grace_drown();
        test_grace_rescue();
`else
        test_no_grace();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
